// File: rtl/stage_mem_pkg.sv
// Shared types and codes for the MEM pipeline stage and its bus interface.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stage_mem_pkg;

  localparam int WORD_W  = 32;
  localparam int WADDR_W = 30;

  // mem_op encoding; 2'b11 is reserved and behaves as NOP
  localparam logic [1:0] MEM_OP_NOP   = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  // exception codes carried down the pipe
  localparam logic [2:0] EXP_NO_EXP     = 3'h0;
  localparam logic [2:0] EXP_MISS_ALIGN = 3'h4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_STALL  = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic [WADDR_W-1:0] pc;
    logic               en;
    logic               br_flag;
    logic [1:0]         ctrl_op;
    logic [4:0]         dst_addr;
    logic               gpr_we_;
    logic [2:0]         exp_code;
    logic [WORD_W-1:0]  out;
  } memwb_t;

  // Value the MEM/WB register takes on reset and flush: a disabled, non-writing slot.
  function automatic memwb_t memwb_bubble();
    memwb_t b;
    b          = '0;
    b.gpr_we_  = 1'b1;
    b.exp_code = EXP_NO_EXP;
    return b;
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Bus master for single-word load/store: request, grant, strobe, wait for ready.
// Latency: busy from the request cycle until the ready cycle (>=3 cycles incl. 1-cycle grant).
// Backpressure: o_busy stalls the pipe; a stall on completion parks read data in a holding register.
module mem_bus_if
  import stage_mem_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_acc_vld,
  input  logic               i_acc_rd,
  input  logic [WADDR_W-1:0] i_acc_addr,
  input  logic [WORD_W-1:0]  i_acc_wr_dat,
  output logic               o_busy,
  output logic [WORD_W-1:0]  o_rd_dat,
  input  logic [WORD_W-1:0]  i_bus_rd_data,
  input  logic               i_bus_rdy_n,
  input  logic               i_bus_grnt_n,
  output logic               o_bus_req_n,
  output logic [WADDR_W-1:0] o_bus_addr,
  output logic               o_bus_as_n,
  output logic               o_bus_rw,
  output logic [WORD_W-1:0]  o_bus_wr_data
);

  bus_state_e        r_state;
  bus_state_e        w_state_nxt;
  logic [WORD_W-1:0] r_rd_hold;
  logic              w_busy;
  logic              w_req;
  logic              w_as;
  logic              w_drive;
  logic              w_done;

  assign w_done = (r_state == ST_ACCESS) && !i_bus_rdy_n;

  // State register and read-data holding register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_rd_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) begin
        r_rd_hold <= i_bus_rd_data;
      end
    end
  end

  // Next state and active-high bus controls; flush is deliberately not an input.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_req       = 1'b0;
    w_as        = 1'b0;
    w_drive     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_acc_vld) begin
          w_req       = 1'b1;
          w_busy      = 1'b1;
          w_drive     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_req   = 1'b1;
        w_busy  = 1'b1;
        w_drive = 1'b1;
        if (!i_bus_grnt_n) begin
          w_as        = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_req   = 1'b1;
        w_drive = 1'b1;
        w_busy  = i_bus_rdy_n;
        if (!i_bus_rdy_n) begin
          w_state_nxt = i_stall ? ST_STALL : ST_IDLE;
        end
      end
      ST_STALL: begin
        if (!i_stall) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are gated by reset so the bus is released the instant reset asserts.
  assign o_busy        = i_rst_n && w_busy;
  assign o_bus_req_n   = !(i_rst_n && w_req);
  assign o_bus_as_n    = !(i_rst_n && w_as);
  assign o_bus_rw      = (i_rst_n && w_drive) ? i_acc_rd : 1'b1;
  assign o_bus_addr    = (i_rst_n && w_drive) ? i_acc_addr : '0;
  assign o_bus_wr_data = (i_rst_n && w_drive) ? i_acc_wr_dat : '0;
  assign o_rd_dat      = (r_state == ST_STALL) ? r_rd_hold : i_bus_rd_data;

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: load/store decode, alignment check, forwarding mux, MEM/WB register.
// Latency: 1 cycle for NOP/misaligned; loads/stores complete on the bus ready cycle.
// Backpressure: busy is ORed into stall upstream; stall holds MEM/WB and wins over flush.
module stage_mem
  import stage_mem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [WADDR_W-1:0] ex_pc,
  input  logic               ex_en,
  input  logic               ex_br_flag,
  input  logic [1:0]         ex_mem_op,
  input  logic [WORD_W-1:0]  ex_mem_wr_data,
  input  logic [1:0]         ex_ctrl_op,
  input  logic [4:0]         ex_dst_addr,
  input  logic               ex_gpr_we_,
  input  logic [2:0]         ex_exp_code,
  input  logic [WORD_W-1:0]  ex_out,
  output logic               busy,
  output logic [WORD_W-1:0]  fwd_data,
  input  logic [WORD_W-1:0]  bus_rd_data,
  input  logic               bus_rdy_,
  input  logic               bus_grnt_,
  output logic               bus_req_,
  output logic [WADDR_W-1:0] bus_addr,
  output logic               bus_as_,
  output logic               bus_rw,
  output logic [WORD_W-1:0]  bus_wr_data,
  output logic [WADDR_W-1:0] mem_pc,
  output logic               mem_en,
  output logic               mem_br_flag,
  output logic [1:0]         mem_ctrl_op,
  output logic [4:0]         mem_dst_addr,
  output logic               mem_gpr_we_,
  output logic [2:0]         mem_exp_code,
  output logic [WORD_W-1:0]  mem_out
);

  logic              w_load;
  logic              w_ls;
  logic              w_misalign;
  logic              w_acc_vld;
  logic              w_busy;
  logic [WORD_W-1:0] w_rd_dat;
  logic [WORD_W-1:0] w_fwd;
  memwb_t            w_memwb_nxt;
  memwb_t            r_memwb;
  logic              r_flush_pend;

  assign w_load     = (ex_mem_op == MEM_OP_LOAD);
  assign w_ls       = ex_en && (w_load || (ex_mem_op == MEM_OP_STORE));
  assign w_misalign = w_ls && (ex_out[1:0] != 2'b00);
  assign w_acc_vld  = w_ls && !w_misalign;

  mem_bus_if u_bus (
    .i_clk         (clk),
    .i_rst_n       (reset),
    .i_stall       (stall),
    .i_acc_vld     (w_acc_vld),
    .i_acc_rd      (w_load),
    .i_acc_addr    (ex_out[WORD_W-1:2]),
    .i_acc_wr_dat  (ex_mem_wr_data),
    .o_busy        (w_busy),
    .o_rd_dat      (w_rd_dat),
    .i_bus_rd_data (bus_rd_data),
    .i_bus_rdy_n   (bus_rdy_),
    .i_bus_grnt_n  (bus_grnt_),
    .o_bus_req_n   (bus_req_),
    .o_bus_addr    (bus_addr),
    .o_bus_as_n    (bus_as_),
    .o_bus_rw      (bus_rw),
    .o_bus_wr_data (bus_wr_data)
  );

  assign busy = w_busy;

  // Forwarding mux: misaligned yields 0, aligned load yields bus/held data, else the ALU result.
  always_comb begin
    w_fwd = ex_out;
    if (w_misalign) begin
      w_fwd = '0;
    end else if (w_acc_vld && w_load) begin
      w_fwd = w_rd_dat;
    end
  end

  // Candidate MEM/WB contents; a misaligned access becomes a non-writing exception slot.
  always_comb begin
    w_memwb_nxt          = '0;
    w_memwb_nxt.pc       = ex_pc;
    w_memwb_nxt.en       = ex_en;
    w_memwb_nxt.br_flag  = ex_br_flag;
    w_memwb_nxt.ctrl_op  = ex_ctrl_op;
    w_memwb_nxt.dst_addr = ex_dst_addr;
    w_memwb_nxt.gpr_we_  = w_misalign ? 1'b1 : ex_gpr_we_;
    w_memwb_nxt.exp_code = w_misalign ? EXP_MISS_ALIGN : ex_exp_code;
    w_memwb_nxt.out      = w_fwd;
  end

  // A flush seen while a bus access holds the pipe is remembered until the access completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flush_pend <= 1'b0;
    end else if (!stall) begin
      r_flush_pend <= 1'b0;
    end else if (flush && w_busy) begin
      r_flush_pend <= 1'b1;
    end
  end

  // MEM/WB register: stall holds, flush (live or pending) loads a bubble, otherwise advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_memwb <= memwb_bubble();
    end else if (!stall) begin
      if (flush || r_flush_pend) begin
        r_memwb <= memwb_bubble();
      end else begin
        r_memwb <= w_memwb_nxt;
      end
    end
  end

  assign fwd_data     = w_fwd;
  assign mem_pc       = r_memwb.pc;
  assign mem_en       = r_memwb.en;
  assign mem_br_flag  = r_memwb.br_flag;
  assign mem_ctrl_op  = r_memwb.ctrl_op;
  assign mem_dst_addr = r_memwb.dst_addr;
  assign mem_gpr_we_  = r_memwb.gpr_we_;
  assign mem_exp_code = r_memwb.exp_code;
  assign mem_out      = r_memwb.out;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem with a scoreboard of expected MEM/WB contents.
// Latency: bench drives bus grant/ready at fixed cycle offsets.
// Backpressure: stall into the DUT is busy ORed with a bench-driven stall.
`define CHK(tag, o, e) begin \
  n_cmp++; \
  assert ((o) === (e)) else begin \
    n_err++; \
    $error("FAIL %s: observed %0h expected %0h", tag, (o), (e)); \
  end \
end

module tb_stage_mem;
  import stage_mem_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, tb_stall, stall, flush;
  logic [29:0] ex_pc;
  logic        ex_en, ex_br_flag, ex_gpr_we_;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;
  logic        busy;
  logic [31:0] fwd_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_, bus_grnt_, bus_req_, bus_as_, bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [29:0] mem_pc;
  logic        mem_en, mem_br_flag, mem_gpr_we_;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;

  assign stall = busy | tb_stall;

  stage_mem dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .busy(busy), .fwd_data(fwd_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
    .bus_grnt_(bus_grnt_), .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  memwb_t sb_q[$];
  memwb_t exp_last;
  memwb_t obs;

  always_comb begin
    obs          = '0;
    obs.pc       = mem_pc;
    obs.en       = mem_en;
    obs.br_flag  = mem_br_flag;
    obs.ctrl_op  = mem_ctrl_op;
    obs.dst_addr = mem_dst_addr;
    obs.gpr_we_  = mem_gpr_we_;
    obs.exp_code = mem_exp_code;
    obs.out      = mem_out;
  end

  function automatic memwb_t bubble();
    memwb_t e;
    e         = '0;
    e.gpr_we_ = 1'b1;
    return e;
  endfunction

  // Expected MEM/WB contents for the instruction currently driven on ex_*.
  function automatic memwb_t model(input logic [31:0] out, input logic misal);
    memwb_t e;
    e.pc       = ex_pc;
    e.en       = ex_en;
    e.br_flag  = ex_br_flag;
    e.ctrl_op  = ex_ctrl_op;
    e.dst_addr = ex_dst_addr;
    e.gpr_we_  = misal ? 1'b1 : ex_gpr_we_;
    e.exp_code = misal ? 3'h4 : ex_exp_code;
    e.out      = out;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [29:0] pc, input logic en, input logic [1:0] op,
                        input logic [31:0] out, input logic [31:0] wd, input logic [4:0] dst,
                        input logic we_, input logic [2:0] ec);
    ex_pc = pc; ex_en = en; ex_mem_op = op; ex_out = out; ex_mem_wr_data = wd;
    ex_dst_addr = dst; ex_gpr_we_ = we_; ex_exp_code = ec;
    ex_br_flag = pc[0]; ex_ctrl_op = pc[2:1];
  endtask

  task automatic pop_chk(input string tag);
    memwb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      n_cmp--;
      e = sb_q.pop_front();
      `CHK({tag, " memwb"}, obs, e)
      exp_last = e;
    end
  endtask

  // Runs one aligned access with grant one cycle after request and ready two cycles later.
  task automatic access(input string tag, input logic [31:0] rdata, input int stall_n,
                        input logic flush_mid);
    int   busy_n;
    logic is_load;
    busy_n  = 0;
    is_load = (ex_mem_op == MEM_OP_LOAD);
    @(negedge clk);
    `CHK({tag, " req0"}, bus_req_, 1'b0)
    `CHK({tag, " addr"}, bus_addr, ex_out[31:2])
    `CHK({tag, " rw"}, bus_rw, is_load)
    if (!is_load) `CHK({tag, " wdat"}, bus_wr_data, ex_mem_wr_data)
    if (busy) busy_n++;
    tick(); bus_grnt_ = 1'b0;
    @(negedge clk);
    `CHK({tag, " as"}, bus_as_, 1'b0)
    `CHK({tag, " hold1"}, obs, exp_last)
    if (busy) busy_n++;
    tick(); bus_grnt_ = 1'b1; flush = flush_mid;
    @(negedge clk);
    `CHK({tag, " as_off"}, bus_as_, 1'b1)
    `CHK({tag, " req_acc"}, bus_req_, 1'b0)
    if (busy) busy_n++;
    tick(); flush = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = rdata; tb_stall = (stall_n > 0);
    @(negedge clk);
    `CHK({tag, " busy_rdy"}, busy, 1'b0)
    `CHK({tag, " fwd_rdy"}, fwd_data, (is_load ? rdata : ex_out))
    `CHK({tag, " busy_cycles"}, busy_n, 3)
    for (int k = 1; k <= stall_n; k++) begin
      tick(); bus_rdy_ = 1'b1; bus_rd_data = 32'h0BAD0BAD; tb_stall = (k < stall_n);
      @(negedge clk);
      `CHK({tag, " st_stall"}, dut.u_bus.r_state, ST_STALL)
      `CHK({tag, " fwd_held"}, fwd_data, rdata)
      `CHK({tag, " mem_held"}, obs, exp_last)
      `CHK({tag, " busy_stall"}, busy, 1'b0)
    end
    tick(); bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; tb_stall = 1'b0;
    ex_en = 1'b0; ex_mem_op = MEM_OP_NOP;
    pop_chk(tag);
  endtask

  initial begin
    tb_stall = 1'b0; flush = 1'b0; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = '0;
    exp_last = bubble();
    // A valid load is presented during reset; the bus must stay released.
    set_ex(30'h11, 1'b1, MEM_OP_LOAD, 32'h100, 32'hAAAA5555, 5'd3, 1'b0, 3'd0);
    reset = 1'b1;
    #2 reset = 1'b0;
    #10;
    `CHK("rst req", bus_req_, 1'b1)
    `CHK("rst as", bus_as_, 1'b1)
    `CHK("rst rw", bus_rw, 1'b1)
    `CHK("rst addr", bus_addr, 30'h0)
    `CHK("rst wdat", bus_wr_data, 32'h0)
    `CHK("rst busy", busy, 1'b0)
    `CHK("rst memwb", obs, bubble())
    `CHK("rst hold", dut.u_bus.r_rd_hold, 32'h0)

    // NOP passes ex_out through in one cycle with no bus activity.
    @(negedge clk);
    set_ex(30'h22, 1'b1, MEM_OP_NOP, 32'd30, 32'h0, 5'd4, 1'b0, 3'd2);
    reset = 1'b1;
    #1;
    `CHK("nop req", bus_req_, 1'b1)
    `CHK("nop busy", busy, 1'b0)
    `CHK("nop fwd", fwd_data, 32'd30)
    sb_q.push_back(model(32'd30, 1'b0));
    tick();
    pop_chk("nop");

    // Aligned load.
    set_ex(30'h33, 1'b1, MEM_OP_LOAD, 32'h100, 32'h0, 5'd7, 1'b0, 3'd0);
    sb_q.push_back(model(32'hDEADBEEF, 1'b0));
    access("load", 32'hDEADBEEF, 0, 1'b0);

    // Aligned store keeps the instruction's write-enable.
    set_ex(30'h44, 1'b1, MEM_OP_STORE, 32'h204, 32'h12345678, 5'd9, 1'b0, 3'd0);
    sb_q.push_back(model(32'h204, 1'b0));
    access("store", 32'h55555555, 0, 1'b0);

    // Misaligned load: no bus cycle, exception code, write disabled.
    set_ex(30'h55, 1'b1, MEM_OP_LOAD, 32'h102, 32'h0, 5'd10, 1'b0, 3'd0);
    @(negedge clk);
    `CHK("mis req", bus_req_, 1'b1)
    `CHK("mis busy", busy, 1'b0)
    `CHK("mis fwd", fwd_data, 32'h0)
    sb_q.push_back(model(32'h0, 1'b1));
    tick();
    pop_chk("mis");
    @(negedge clk);
    `CHK("mis req2", bus_req_, 1'b1)

    // Disabled load never reaches the bus.
    tick();
    set_ex(30'h66, 1'b0, MEM_OP_LOAD, 32'h180, 32'h0, 5'd11, 1'b0, 3'd0);
    @(negedge clk);
    `CHK("dis req", bus_req_, 1'b1)
    `CHK("dis busy", busy, 1'b0)
    sb_q.push_back(model(32'h180, 1'b0));
    tick();
    pop_chk("dis");

    // Load completing under a three-cycle stall.
    set_ex(30'h77, 1'b1, MEM_OP_LOAD, 32'h104, 32'h0, 5'd12, 1'b0, 3'd1);
    sb_q.push_back(model(32'hCAFEF00D, 1'b0));
    access("stall_ld", 32'hCAFEF00D, 3, 1'b0);

    // Flush pulse during ACCESS: transaction completes, then the bubble loads.
    set_ex(30'h88, 1'b1, MEM_OP_LOAD, 32'h108, 32'h0, 5'd13, 1'b0, 3'd0);
    sb_q.push_back(bubble());
    access("flush_acc", 32'h01020304, 0, 1'b0 | 1'b1);

    // Flush without stall.
    set_ex(30'h99, 1'b1, MEM_OP_NOP, 32'h55, 32'h0, 5'd14, 1'b0, 3'd0);
    flush = 1'b1;
    sb_q.push_back(bubble());
    tick();
    flush = 1'b0;
    pop_chk("flush");

    // Stall wins over flush, and the flush is not remembered without a bus access.
    set_ex(30'hAA, 1'b1, MEM_OP_NOP, 32'h66, 32'h0, 5'd15, 1'b0, 3'd3);
    tb_stall = 1'b1; flush = 1'b1;
    tick();
    `CHK("stall_flush hold", obs, exp_last)
    tb_stall = 1'b0; flush = 1'b0;
    sb_q.push_back(model(32'h66, 1'b0));
    tick();
    pop_chk("after_stall");

    // Reset while granted and strobing releases the bus at once.
    set_ex(30'hBB, 1'b1, MEM_OP_STORE, 32'h300, 32'hFEEDFACE, 5'd16, 1'b0, 3'd0);
    tick();
    bus_grnt_ = 1'b0;
    @(negedge clk);
    `CHK("mid as_pre", bus_as_, 1'b0)
    #1 reset = 1'b0;
    #1;
    `CHK("mid req", bus_req_, 1'b1)
    `CHK("mid as", bus_as_, 1'b1)
    `CHK("mid busy", busy, 1'b0)
    `CHK("mid rw", bus_rw, 1'b1)
    `CHK("mid addr", bus_addr, 30'h0)
    `CHK("mid wdat", bus_wr_data, 32'h0)
    `CHK("mid memwb", obs, bubble())
    bus_grnt_ = 1'b1;
    set_ex(30'hCC, 1'b1, MEM_OP_NOP, 32'd5, 32'h0, 5'd17, 1'b1, 3'd0);
    #1 reset = 1'b1;
    sb_q.push_back(model(32'd5, 1'b0));
    tick();
    pop_chk("post_rst");
    `CHK("sb empty", sb_q.size(), 0)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
